// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch front-end.
//   PC_W      - PC / instruction-memory address width
//   INSTR_W   - instruction word width
//   MEM_LAST  - highest fetchable address (halt point when IFETCH_HALT_EN is defined)
//   OP_BEQ    - branch-equal opcode, shared with decode
//   fetch_entry_t - {pc, instr} pair carried from fetch to decode
//   state_t   - fetch FSM states
package ifetch_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  localparam logic [PC_W-1:0] MEM_LAST = 8'hFF;
  localparam logic [2:0]      OP_BEQ   = 3'b100;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    HALT
  } state_t;

endpackage

// File: rtl/ifetch_skid_fifo.sv
// ifetch_skid_fifo: 2-entry FIFO of fetch_entry_t that absorbs decode stalls.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   push, push_data   - write an entry at the end of the cycle
//   pop               - remove the head entry (ignored when empty)
//   flush             - discard all entries; wins over push and pop
//   count             - number of valid entries (0..2)
//   head, head_valid  - oldest entry and its valid flag
module ifetch_skid_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         head_valid
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop     = pop & (count != 2'd0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push    = push & ((count != 2'd2) | do_pop);
  assign head       = mem[rd_ptr];
  assign head_valid = (count != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: initiator side of the synchronous-read instruction memory port.
// Presents imem_pc every cycle, captures imem_rd one cycle later and hands {pc, instr}
// to decode through a 2-entry skid FIFO with a valid/ready handshake.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   imem_pc                     - registered address to instruction memory
//   imem_rd                     - memory read data for last cycle's address
//   instr_valid/instr_ready     - handshake toward decode
//   instr, instr_pc             - head instruction word and its address
//   redirect_valid/redirect_pc  - one-cycle pulse restarting fetch at redirect_pc
//   halted                      - fetch stopped at MEM_LAST
// Build option: define IFETCH_HALT_EN to stop fetch after MEM_LAST and enter HALT;
// otherwise the PC wraps modulo 2**PC_W and halted is tied low.
module instr_fetch_unit
  import ifetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_rd,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t          state;
  logic            inflight;   // address presented last cycle is wanted
  logic [PC_W-1:0] prev_pc;    // address presented last cycle
  logic [1:0]      count;
  logic [2:0]      occ;
  logic            deq;
  logic            issue;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            head_valid;

`ifdef IFETCH_HALT_EN
  logic last_issued;           // MEM_LAST has been issued; no further fetches
`endif

  assign deq         = instr_valid & instr_ready;
  assign instr_valid = head_valid;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  assign push_entry.pc    = prev_pc;
  assign push_entry.instr = imem_rd;

  // Entries that will occupy the FIFO after this cycle if nothing new is issued.
  always_comb begin
    occ   = 3'(count) + 3'(inflight) - 3'(deq);
    issue = (occ < 3'd2) && (state != HALT);
`ifdef IFETCH_HALT_EN
    issue = issue && !last_issued;
`endif
  end

  // Redirect flushes the FIFO; the same flush discards any return arriving this cycle.
  ifetch_skid_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_data  (push_entry),
    .pop        (deq),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head),
    .head_valid (head_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      imem_pc  <= '0;
      inflight <= 1'b0;
      prev_pc  <= '0;
`ifdef IFETCH_HALT_EN
      last_issued <= 1'b0;
      halted      <= 1'b0;
`endif
    end else begin
      prev_pc <= imem_pc;
      if (redirect_valid) begin
        // Clearing inflight kills the return of the address presented this cycle.
        imem_pc  <= redirect_pc;
        inflight <= 1'b0;
        state    <= RUN;
`ifdef IFETCH_HALT_EN
        last_issued <= 1'b0;
        halted      <= 1'b0;
`endif
      end else begin
        unique case (state)
          RUN, STALL: begin
            if (issue) begin
              inflight <= 1'b1;
              state    <= RUN;
`ifdef IFETCH_HALT_EN
              if (imem_pc == MEM_LAST) begin
                last_issued <= 1'b1;
              end else begin
                imem_pc <= imem_pc + PC_ONE;
              end
`else
              imem_pc <= imem_pc + PC_ONE;
`endif
            end else begin
              inflight <= 1'b0;
              state    <= STALL;
`ifdef IFETCH_HALT_EN
              if (last_issued && (count == 2'd0) && !inflight) begin
                state  <= HALT;
                halted <= 1'b1;
              end
`endif
            end
          end
          HALT: begin
            inflight <= 1'b0;
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

`ifndef IFETCH_HALT_EN
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit with a
// synchronous-read instruction memory model. Cycle 0 is the first cycle after reset
// release; outputs are sampled 1 time unit after each rising edge.
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [PC_W-1:0]    imem_pc;
  logic [INSTR_W-1:0] imem_rd;
  logic               instr_valid;
  logic               instr_ready = 1'b1;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               halted;

  logic [INSTR_W-1:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rd <= mem[imem_pc];

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_rd        (imem_rd),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head_is(input string tag, input logic [7:0] pc, input logic [15:0] ins);
    check_eq({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, ".pc"}, 32'(instr_pc), 32'(pc));
    check_eq({tag, ".instr"}, 32'(instr), 32'(ins));
  endtask

  task automatic no_head(input string tag);
    check_eq({tag, ".valid"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic outputs_zero(input string tag);
    check_eq({tag, ".imem_pc"}, 32'(imem_pc), 32'd0);
    check_eq({tag, ".valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, ".instr"}, 32'(instr), 32'd0);
    check_eq({tag, ".instr_pc"}, 32'(instr_pc), 32'd0);
    check_eq({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  // Leaves the bench in cycle 0 after reset release.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    tick();
    outputs_zero("rst");
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hC3, 8'(i)};
    mem[0] = 16'h489A;
    mem[1] = 16'h2D05;
    mem[2] = 16'h11A0;
    mem[3] = 16'h20FF;

    // Straight-line fetch with decode always ready.
    do_reset();
    check_eq("c0.imem_pc", 32'(imem_pc), 32'h00);
    no_head("c0");
    tick();
    check_eq("c1.imem_pc", 32'(imem_pc), 32'h01);
    no_head("c1");
    tick(); head_is("run.c2", 8'h00, 16'h489A);
    tick(); head_is("run.c3", 8'h01, 16'h2D05);
    tick(); head_is("run.c4", 8'h02, 16'h11A0);
    tick(); head_is("run.c5", 8'h03, 16'h20FF);

    // Decode stall for 5 cycles from the first valid.
    do_reset();
    instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      head_is("stall", 8'h00, 16'h489A);
      check_eq("stall.imem_pc", 32'(imem_pc), 32'h02);
    end
    tick();
    head_is("release.c7", 8'h00, 16'h489A);
    instr_ready = 1'b1;
    tick(); head_is("release.c8", 8'h01, 16'h2D05);
    tick(); head_is("release.c9", 8'h02, 16'h11A0);
    tick(); head_is("release.c10", 8'h03, 16'h20FF);

    // Redirect to 0x02 in the cycle pc 0x01 is accepted.
    do_reset();
    tick();
    tick(); head_is("redir.c2", 8'h00, 16'h489A);
    tick(); head_is("redir.c3", 8'h01, 16'h2D05);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h02;
    tick();
    redirect_valid = 1'b0;
    no_head("redir.c4");
    check_eq("redir.c4.imem_pc", 32'(imem_pc), 32'h02);
    tick(); no_head("redir.c5");
    tick(); head_is("redir.c6", 8'h02, 16'h11A0);
    tick(); head_is("redir.c7", 8'h03, 16'h20FF);

    // Redirect near the top of memory (issued in cycle 7).
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    no_head("top.c8");
    check_eq("top.c8.imem_pc", 32'(imem_pc), 32'hFE);
    tick(); no_head("top.c9");
    tick(); head_is("top.c10", 8'hFE, 16'hC3FE);
    tick(); head_is("top.c11", 8'hFF, 16'hC3FF);
`ifdef IFETCH_HALT_EN
    tick(); no_head("halt.c12");
    tick(); no_head("halt.c13");
    check_eq("halt.c13.halted", 32'(halted), 32'd1);
    tick(); no_head("halt.c14");
    check_eq("halt.c14.halted", 32'(halted), 32'd1);
    check_eq("halt.c14.imem_pc", 32'(imem_pc), 32'hFF);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h01;
    tick();
    redirect_valid = 1'b0;
    check_eq("unhalt.c15.halted", 32'(halted), 32'd0);
    no_head("unhalt.c15");
    tick(); no_head("unhalt.c16");
    tick(); head_is("unhalt.c17", 8'h01, 16'h2D05);
`else
    tick(); head_is("wrap.c12", 8'h00, 16'h489A);
    check_eq("wrap.c12.halted", 32'(halted), 32'd0);
    tick(); head_is("wrap.c13", 8'h01, 16'h2D05);
`endif

    // Asynchronous reset while a valid entry is at the head.
    do_reset();
    tick();
    tick();
    tick(); head_is("arst.c3", 8'h01, 16'h2D05);
    #3 reset = 1'b1;
    #1 outputs_zero("arst.now");
    tick();
    reset = 1'b0;
    check_eq("arst.c0.imem_pc", 32'(imem_pc), 32'h00);
    tick(); no_head("arst.c1");
    tick(); head_is("arst.c2", 8'h00, 16'h489A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front-end for the 16-bit core: the initiator side of the instruction-memory read port. It drives the 8-bit PC into the synchronous-read instruction memory, captures the returned word one cycle later, and delivers {pc, instr} to decode over a valid/ready handshake. A 2-entry skid FIFO absorbs decode stalls, and a redirect port lets branch resolution (e.g. beq, opcode 3'b100) steer fetch.

## Interface
- PC_W, 8, PC / instruction-memory address width
- INSTR_W, 16, instruction word width
- MEM_LAST, 8'hFF, highest fetchable address
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_pc  out  PC_W  address presented to instruction memory, registered
- imem_rd  in  INSTR_W  memory read data, valid the cycle after the address was presented
- instr_valid  out  1  head entry valid toward decode
- instr_ready  in  1  decode accepts head; transfer when both high
- instr  out  INSTR_W  head instruction word
- instr_pc  out  PC_W  address of head instruction
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  PC_W  redirect target
- halted  out  1  fetch stopped at MEM_LAST (only with IFETCH_HALT_EN; tied 0 otherwise)

## Operation
- Memory samples imem_pc every posedge; the unit tracks with an `inflight` flag whether the address presented last cycle is wanted.
- FSM: RUN, STALL, HALT. RUN issues one fetch per cycle. STALL holds imem_pc when count + inflight − deq ≥ 2. HALT is IFETCH_HALT_EN only.
- Issue condition: count + inflight − (instr_valid & instr_ready) < 2. On issue, imem_pc <= imem_pc + 1 (PC_W-bit wrap) and inflight <= 1. Otherwise imem_pc holds and inflight <= 0.
- Return: when inflight, push {imem_pc_prev, imem_rd} into the FIFO at the end of the cycle. The FIFO never overflows given the issue rule.
- Redirect (highest priority): a handshake in the same cycle still completes. Then at the edge:
  - FIFO flushed
  - any inflight return discarded via a kill flag
  - imem_pc <= redirect_pc, marked issued
  - HALT cleared → RUN
- Simultaneous push and pop: both happen; count is unchanged.
- Reset mid-operation: all state cleared asynchronously. Fetch restarts from address 0.

## Timing
- Reset values:
  - imem_pc = 0, instr_valid = 0, instr = 0, instr_pc = 0, halted = 0
  - count = 0, inflight = 0, state = RUN
- First cycle after reset release (cycle 0): imem_pc = 0 is issued.
- Latency: address presented in cycle N → imem_rd in N+1 → instr_valid in N+2 (no bypass).
- Redirect seen in cycle N → imem_pc = target in N+1 → target instr_valid in N+3. instr_valid is low in N+1 and N+2.
- Sustained throughput with instr_ready high: 1 instruction/cycle.
- instr and instr_pc are stable while instr_valid & !instr_ready.

## Configuration
- IFETCH_HALT_EN defined:
  - After issuing MEM_LAST, the unit stops issuing; imem_pc holds MEM_LAST.
  - Once FIFO and inflight are empty, it enters HALT and asserts halted.
  - Only redirect or reset leaves HALT.
- IFETCH_HALT_EN undefined: PC wraps MEM_LAST → 0 (PC_W modulo); halted is constant 0.

## Structure
- Package ifetch_pkg:
  - PC_W, INSTR_W
  - fetch_entry_t struct {pc, instr}
  - state enum {RUN, STALL, HALT}
  - OP_BEQ = 3'b100 (shared with decode)
- Sub-module ifetch_skid_fifo: 2-entry fetch_entry_t FIFO with push, pop, flush, count[1:0], head outputs.

## Test plan
Memory preload: 0x00=0x489A, 0x01=0x2D05, 0x02=0x11A0, 0x03=0x20FF.
- Reset release, instr_ready=1 → instr_valid first high in cycle 2 with pc 0x00/0x489A; then 0x01/0x2D05, 0x02/0x11A0, 0x03/0x20FF on consecutive cycles.
- Hold instr_ready=0 from the first valid for 5 cycles → instr stays pc 0x00/0x489A; imem_pc freezes at 0x02. On release, pcs 0x01, 0x02, 0x03 arrive back-to-back with none lost or duplicated.
- redirect_valid with redirect_pc=0x02 in the cycle pc 0x01 is accepted → instr_valid low for 2 cycles, then pc 0x02/0x11A0. No stale pc 0x02/0x03 from before the redirect appears.
- Redirect to 0xFE, instr_ready=1:
  - Macro off: pcs 0xFE, 0xFF, 0x00 (0x489A).
  - Macro on: 0xFE, 0xFF, then halted=1 and no further valid. A redirect to 0x01 clears halted and delivers 0x2D05.
- Assert reset while instr_valid=1 → all outputs 0 immediately (asynchronous); after release, fetch restarts with pc 0x00 valid in cycle 2.
